mux_nway_pipe: RTL and testbench
================================

Name: mux_nway_pipe

Overview:
- Parametrised successor to the 16-bit 2:1 datapath mux: NCH channels of WIDTH bits, selected into one registered output with valid/ready handshakes.
- Two modes: fixed (external select) and round-robin (internal fair arbiter over valid channels).
- Sits between register-file/immediate/ALU-result sources and the downstream datapath stage when sources become multi-cycle or backpressured.

Parameters:
- WIDTH, 16, data width per channel
- NCH, 4, number of input channels (2..16)
- SEL_W, $clog2(NCH) (min 1), select/channel-id width; derived, not overridden

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  NCH  per-channel valid
- in_ready  out  NCH  per-channel ready; at most one bit set per cycle
- mode  in  1  0 = fixed select, 1 = round-robin
- sel  in  SEL_W  channel select in fixed mode; ignored in round-robin
- out_data  out  WIDTH  registered selected data
- out_ch  out  SEL_W  channel id of the word in out_data
- out_valid  out  1  output register holds a word
- out_ready  in  1  downstream accepts

Behaviour:
- Reset is asynchronous and active-low; clock is single-domain. On rst_n low: out_valid=0, out_data=0, out_ch=0, rr pointer=0. Effect is immediate, including mid-transfer; the held word is discarded.
- can_accept = !out_valid || out_ready. Transfer on channel g occurs when in_valid[g] && in_ready[g].
- Latency: 1 cycle from accepted input to out_valid=1.
- Fixed mode: g = sel.
  - in_ready[i] = (i==sel) && can_accept.
  - If sel >= NCH (non-power-of-two NCH): in_ready all 0, no transfer.
- Round-robin mode:
  - g = first index at or after ptr, wrapping modulo NCH, with in_valid set.
  - in_ready[g] = can_accept; all other bits 0. No valid inputs gives no grant.
  - ptr updates to (g+1) mod NCH only on a transfer. It holds while blocked.
- Output register:
  - On transfer: out_data <= channel g data, out_ch <= g, out_valid <= 1.
  - If out_valid && out_ready with no new transfer: out_valid <= 0; out_data and out_ch hold their last values.
  - While out_valid && !out_ready: out_data and out_ch are stable.
- Simultaneous drain and fill: back-to-back transfers at full rate, 1 word/cycle.
- Mode or sel change takes effect in the same cycle's grant (combinational). It never alters a word already in the output register. ptr is preserved across mode switches.
- in_valid dropping without a transfer is legal (no AXI-style stickiness required).

Optional Feature:
- Macro: MUX_NWAY_SKID_EN.
- Defined: adds a 1-entry skid register, so in_ready is a pure function of registered state (skid empty), with no combinational path from out_ready.
  - A transfer taken while out_valid && !out_ready lands in skid.
  - Skid drains to the output first when out_ready rises, preserving order.
  - Throughput stays 1 word/cycle.
- Undefined: in_ready depends combinationally on out_ready as above. No skid storage.

Decomposition:
- Package mux_nway_pkg holds:
  - mode constants MODE_FIXED=1'b0 and MODE_RR=1'b1
  - default WIDTH/NCH constants
  - a clog2-min-1 helper function
- One sub-module, rr_arbiter (NCH, SEL_W). It provides the valid vector, pointer register, grant index, grant-valid flag and an advance strobe.
- The data path stays in the top module.

Test Plan (WIDTH=16, NCH=4 unless noted):
1. rst_n low asynchronously while out_valid=1, out_data=16'h0017 -> out_valid=0, out_data=0, out_ch=0 before the next clk edge. After release, first RR grant goes to channel 0.
2. Fixed: mode=0, sel=2, in_data ch2=16'h0017, in_valid=4'b1111, out_ready=1 -> in_ready=4'b0100. Next cycle out_data=16'h0017, out_ch=2, out_valid=1.
3. Backpressure: out_valid=1, out_ready=0 for 5 cycles while ch2 data changes to 16'h0010 -> out_data stays 16'h0017, in_ready=0 (no skid). The out_ready pulse delivers 16'h0010 next.
4. RR fairness: mode=1, in_valid=4'b1111 constant, out_ready=1 -> out_ch sequence 0,1,2,3,0,1, one per cycle.
5. RR sparse: in_valid=4'b1010 -> out_ch 1,3,1,3. Switching to fixed mode sel=0 with in_valid[0]=1 mid-stream -> next word from ch0, and ptr is unchanged on return to RR.
6. NCH=3, mode=0, sel=3 -> in_ready=3'b000, out_valid stays 0. With MUX_NWAY_SKID_EN: stall out_ready=0 for one cycle during a 4-word burst -> no word lost or reordered.

Source files
------------

// File: rtl/mux_nway_pkg.sv
// ============================================================================
// Module      : mux_nway_pkg
// Description : Shared constants and helpers for the N-way pipelined mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_nway_pkg;

    localparam logic MODE_FIXED    = 1'b0;
    localparam logic MODE_RR       = 1'b1;

    localparam int   DEFAULT_WIDTH = 16;
    localparam int   DEFAULT_NCH   = 4;

    // $clog2 floored at 1 so a 2-channel (or degenerate) build still has a select bit
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_nway_pipe_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin grant over a valid vector; pointer moves past the
//               granted channel only when the owner signals a transfer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import mux_nway_pkg::*;
#(
    parameter int NCH   = DEFAULT_NCH,
    parameter int SEL_W = clog2_min1(NCH)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   valid,
    input  logic             advance,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_valid
);

    localparam logic [SEL_W:0]   c_nch  = (SEL_W+1)'(NCH);
    localparam logic [SEL_W-1:0] c_last = SEL_W'(NCH-1);
    localparam logic [SEL_W-1:0] c_one  = SEL_W'(1);

    logic [SEL_W-1:0] r_ptr;
    logic [2*NCH-1:0] w_dbl;
    logic [NCH-1:0]   w_rot;
    logic [SEL_W-1:0] w_off;
    logic [SEL_W:0]   w_sum;

    // Rotating a doubled vector puts the pointer's channel at bit 0
    assign w_dbl = {valid, valid};
    assign w_rot = NCH'(w_dbl >> r_ptr);

    always_comb begin
        w_off       = '0;
        grant_valid = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off       = SEL_W'(k);
                grant_valid = 1'b1;
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= c_nch) begin
            w_sum = w_sum - c_nch;
        end
        grant_idx = w_sum[SEL_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (grant_idx == c_last) ? '0 : grant_idx + c_one;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_nway_pipe.sv
// ============================================================================
// Module      : mux_nway_pipe
// Description : NCH-channel valid/ready mux with registered output; fixed or
//               round-robin selection. Optional skid: MUX_NWAY_SKID_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_nway_pipe
    import mux_nway_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int NCH   = DEFAULT_NCH,
    localparam int SEL_W = clog2_min1(NCH)
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]     in_valid,
    output logic [NCH-1:0]     in_ready,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_ch,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam logic [SEL_W:0] c_nch = (SEL_W+1)'(NCH);

    logic [WIDTH-1:0] w_ch_data [NCH];
    logic [WIDTH-1:0] w_gdata;
    logic [SEL_W-1:0] w_grant;
    logic [SEL_W-1:0] w_arb_idx;
    logic             w_arb_gv;
    logic             w_sel_ok;
    logic             w_grant_ok;
    logic             w_can_accept;
    logic             w_xfer;
    logic             w_adv;

    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_ch;
    logic             r_out_valid;

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_unpack
            assign w_ch_data[i] = in_data[i*WIDTH +: WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .NCH   (NCH),
        .SEL_W (SEL_W)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid       (in_valid),
        .advance     (w_adv),
        .grant_idx   (w_arb_idx),
        .grant_valid (w_arb_gv)
    );

    // Out-of-range select (non-power-of-two NCH) grants nobody
    assign w_sel_ok = ({1'b0, sel} < c_nch);

    always_comb begin
        if (mode == MODE_RR) begin
            w_grant    = w_arb_idx;
            w_grant_ok = w_arb_gv;
        end else begin
            w_grant    = sel;
            w_grant_ok = w_sel_ok;
        end
    end

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ready
            assign in_ready[i] = w_grant_ok && w_can_accept && (w_grant == SEL_W'(i));
        end
    endgenerate

    assign w_xfer = |(in_valid & in_ready);
    assign w_adv  = w_xfer && (mode == MODE_RR);

    always_comb begin
        w_gdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_grant == SEL_W'(i)) begin
                w_gdata = w_ch_data[i];
            end
        end
    end

`ifdef MUX_NWAY_SKID_EN
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic [SEL_W-1:0] r_skid_ch;
    logic             w_out_free;

    // Ready depends only on skid occupancy, cutting the out_ready -> in_ready path
    assign w_can_accept = !r_skid_valid;
    assign w_out_free   = !r_out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_ch     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_ch    <= '0;
        end else if (r_skid_valid) begin
            if (w_out_free) begin
                r_out_data   <= r_skid_data;
                r_out_ch     <= r_skid_ch;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end
        end else if (w_xfer) begin
            if (w_out_free) begin
                r_out_data  <= w_gdata;
                r_out_ch    <= w_grant;
                r_out_valid <= 1'b1;
            end else begin
                r_skid_data  <= w_gdata;
                r_skid_ch    <= w_grant;
                r_skid_valid <= 1'b1;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
`else
    assign w_can_accept = !r_out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else if (w_xfer) begin
            r_out_data  <= w_gdata;
            r_out_ch    <= w_grant;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_mux_nway_pipe.sv
// ============================================================================
// Module      : tb_mux_nway_pipe
// Description : Directed bench for mux_nway_pipe with a queue-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mux_nway_pipe;
    import mux_nway_pkg::*;

    localparam int W = 16;
    localparam int N = 4;
`ifdef MUX_NWAY_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid, in_ready;
    logic           mode;
    logic [1:0]     sel;
    logic [W-1:0]   out_data;
    logic [1:0]     out_ch;
    logic           out_valid, out_ready;

    logic [3*W-1:0] in_data3;
    logic [2:0]     in_valid3, in_ready3;
    logic           mode3;
    logic [1:0]     sel3;
    logic [W-1:0]   out_data3;
    logic [1:0]     out_ch3;
    logic           out_valid3, out_ready3;

    mux_nway_pipe #(.WIDTH(W), .NCH(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_nway_pipe #(.WIDTH(W), .NCH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
        .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic [1:0]   ch;
    } word_t;

    int           n_pass   = 0;
    int           n_checks = 0;
    word_t        m_q[$];
    word_t        m_last;
    int           m_ptr;
    logic [W-1:0] dut_got[$];

    int           t4_seq[6] = '{0, 1, 2, 3, 0, 1};
    int           t5_seq[5] = '{1, 3, 1, 3, 1};
    logic [W-1:0] burst[4]  = '{16'hB000, 16'hB001, 16'hB002, 16'hB003};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [W-1:0] v);
        in_data[c*W +: W] = v;
    endtask

    // Which channel the rules say is offered this cycle
    function automatic void model_grant(output int g, output bit ok);
        g  = 0;
        ok = 1'b0;
        if (mode == MODE_FIXED) begin
            if (int'(sel) < N) begin
                g  = int'(sel);
                ok = 1'b1;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (!ok && in_valid[j]) begin
                    g  = j;
                    ok = 1'b1;
                end
            end
        end
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        bit ok;
        bit can;
        model_grant(g, ok);
        can = SKID ? (m_q.size() < 2) : (m_q.size() == 0 || out_ready);
        return (ok && can) ? N'(1 << g) : '0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_ptr  = 0;
            m_last = '0;
        end else begin
            int          g;
            bit          ok;
            logic [N-1:0] r;
            model_grant(g, ok);
            r = exp_ready();
            if (m_q.size() > 0 && out_ready) m_last = m_q.pop_front();
            if ((r & in_valid) != '0) begin
                m_q.push_back({in_data[g*W +: W], 2'(g)});
                if (mode == MODE_RR) m_ptr = (g + 1) % N;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", out_data, 0);
            check("rst_out_ch", out_ch, 0);
        end else begin
            word_t shown;
            shown = (m_q.size() > 0) ? m_q[0] : m_last;
            check("in_ready", in_ready, exp_ready());
            check("out_valid", out_valid, m_q.size() > 0);
            check("out_data", out_data, shown.d);
            check("out_ch", out_ch, shown.ch);
            if (out_valid && out_ready) dut_got.push_back(out_data);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           base, k, cyc;
        logic         acc;
        logic [31:0]  got;

        rst_n = 1'b0; in_data = '0; in_valid = '0; mode = MODE_FIXED; sel = '0; out_ready = 1'b1;
        in_data3 = '0; in_valid3 = '0; mode3 = MODE_FIXED; sel3 = '0; out_ready3 = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        check("init_valid", out_valid, 0);

        // Fixed select of channel 2
        set_ch(0, 16'hA000); set_ch(1, 16'hA001); set_ch(2, 16'h0017); set_ch(3, 16'hA003);
        in_valid = 4'b1111; sel = 2'd2;
        #1 check("t2_in_ready", in_ready, 4'b0100);
        tick();
        check("t2_data", out_data, 16'h0017);
        check("t2_ch", out_ch, 2);
        check("t2_valid", out_valid, 1);

        // Backpressure holds the output word
        out_ready = 1'b0;
        set_ch(2, 16'h0010);
        for (int i = 0; i < 5; i++) begin
            #1;
`ifndef MUX_NWAY_SKID_EN
            check("t3_in_ready", in_ready, 4'b0000);
`endif
            tick();
            check("t3_hold", out_data, 16'h0017);
        end
        out_ready = 1'b1;
        tick();
        check("t3_next", out_data, 16'h0010);
        check("t3_valid", out_valid, 1);
        in_valid = '0;
        repeat (3) tick();

        // Asynchronous reset while a word is held
        set_ch(2, 16'h0017); in_valid = 4'b0100;
        tick();
        in_valid = '0; out_ready = 1'b0;
        check("t1_pre_data", out_data, 16'h0017);
        #2 rst_n = 1'b0;
        #1;
        check("t1_valid", out_valid, 0);
        check("t1_data", out_data, 0);
        check("t1_ch", out_ch, 0);
        tick();
        rst_n = 1'b1; out_ready = 1'b1;

        // Round-robin fairness
        mode = MODE_RR; in_valid = 4'b1111;
        set_ch(0, 16'hC000); set_ch(1, 16'hC001); set_ch(2, 16'hC002); set_ch(3, 16'hC003);
        #1 check("t4_first_grant", in_ready, 4'b0001);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t4_ch", out_ch, t4_seq[i]);
        end
        check("t4_data", out_data, 16'hC001);

        in_valid = '0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Sparse round-robin, then a fixed-mode detour
        in_valid = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_ch", out_ch, t5_seq[i]);
        end
        mode = MODE_FIXED; sel = 2'd0; in_valid = 4'b1011;
        #1 check("t5_fixed_ready", in_ready, 4'b0001);
        tick();
        check("t5_fixed_ch", out_ch, 0);
        check("t5_fixed_data", out_data, 16'hC000);
        mode = MODE_RR; in_valid = 4'b1010;
        #1 check("t5_ptr_kept", in_ready, 4'b1000);
        tick();
        check("t5_rr_ch", out_ch, 3);
        in_valid = '0;
        repeat (2) tick();

        // Three-channel instance with an out-of-range select
        mode3 = MODE_FIXED; sel3 = 2'd3; in_valid3 = 3'b111;
        in_data3 = {16'h3002, 16'h3001, 16'h3000};
        #1 check("t6_ready_none", in_ready3, 3'b000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_no_valid", out_valid3, 0);
        end
        sel3 = 2'd2;
        #1 check("t6_sel2_ready", in_ready3, 3'b100);
        tick();
        check("t6_sel2_valid", out_valid3, 1);
        check("t6_sel2_data", out_data3, 16'h3002);
        check("t6_sel2_ch", out_ch3, 2);
        in_valid3 = '0;

        // Four-word burst with a one-cycle stall
        mode = MODE_FIXED; sel = 2'd1; out_ready = 1'b1;
        base = dut_got.size(); k = 0; cyc = 0;
        while (k < 4 && cyc < 40) begin
            set_ch(1, burst[k]);
            in_valid  = 4'b0010;
            out_ready = (cyc != 1);
            @(negedge clk);
            acc = in_ready[1];
            tick();
            if (acc) k++;
            cyc++;
        end
        check("burst_budget", k, 4);
        in_valid = '0; out_ready = 1'b1;
        repeat (4) tick();
        check("burst_count", dut_got.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            got = (base + i < dut_got.size()) ? 32'(dut_got[base + i]) : 32'hFFFF_FFFF;
            check("burst_word", got, 32'(burst[i]));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
